// File: rtl/regfile_scoreboard_if.sv
// Register-file bus between decode/issue (master) and the register file (slave).
// Carries two read ports, the writeback port, the issue reservation port and
// the pending-entry count.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_busy;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_busy;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_vld;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_rdy;
    logic [ADDR_W:0]   pending_cnt;

    // Decode/issue and writeback side.
    modport master (
        output rd0_addr, rd1_addr, we, wr_addr, wr_data, issue_vld, issue_addr,
        input  rd0_data, rd0_busy, rd1_data, rd1_busy, issue_rdy, pending_cnt
    );

    // Register file side.
    modport slave (
        input  rd0_addr, rd1_addr, we, wr_addr, wr_data, issue_vld, issue_addr,
        output rd0_data, rd0_busy, rd1_data, rd1_busy, issue_rdy, pending_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, an
// optional hardwired zero register, optional write-to-read bypass and a
// per-register pending scoreboard used by decode to stall on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [CNT_W-1:0]  pending_cnt_q;

    logic wr_eff;      // write that actually lands in the array
    logic issue_acc;   // accepted issue that actually reserves an entry
    logic cnt_set;
    logic cnt_clear;

    // Entry 0 is hardwired to zero only when ZERO_REG is enabled.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Read port 0: zero register, then bypass from writeback, then the array.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        bus.rd0_data = mem[bus.rd0_addr];
        bus.rd0_busy = pending[bus.rd0_addr];
        if (is_zero(bus.rd0_addr)) begin
            bus.rd0_data = '0;
            bus.rd0_busy = 1'b0;
        end else if (BYPASS && bus.we && (bus.wr_addr == bus.rd0_addr)) begin
            bus.rd0_data = bus.wr_data;
            bus.rd0_busy = 1'b0;
        end
    end

    // Read port 1: same priority as port 0, evaluated independently.
    always_comb begin
        bus.rd1_data = mem[bus.rd1_addr];
        bus.rd1_busy = pending[bus.rd1_addr];
        if (is_zero(bus.rd1_addr)) begin
            bus.rd1_data = '0;
            bus.rd1_busy = 1'b0;
        end else if (BYPASS && bus.we && (bus.wr_addr == bus.rd1_addr)) begin
            bus.rd1_data = bus.wr_data;
            bus.rd1_busy = 1'b0;
        end
    end

    // Reservation handshake and the pending-count increment/decrement terms.
    always_comb begin
        wr_eff        = bus.we && !is_zero(bus.wr_addr);
        bus.issue_rdy = is_zero(bus.issue_addr) || !pending[bus.issue_addr]
                        || (bus.we && (bus.wr_addr == bus.issue_addr));
        issue_acc     = bus.issue_vld && bus.issue_rdy && !is_zero(bus.issue_addr);
        // A re-issue of an entry retiring this cycle keeps it pending: net change 0.
        cnt_set       = issue_acc && !pending[bus.issue_addr];
        cnt_clear     = wr_eff && pending[bus.wr_addr]
                        && !(issue_acc && (bus.issue_addr == bus.wr_addr));
    end

    // Array write and scoreboard update; reservation wins over a same-entry retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is cleared on reset because reads must return 0 right after it; this costs a reset net per flop.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending       <= '0;
            pending_cnt_q <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every update sees pre-edge values.
            if (wr_eff) begin
                mem[bus.wr_addr]     <= bus.wr_data;
                pending[bus.wr_addr] <= 1'b0;
            end
            if (issue_acc) begin
                pending[bus.issue_addr] <= 1'b1;
            end
            pending_cnt_q <= pending_cnt_q + CNT_W'(cnt_set) - CNT_W'(cnt_clear);
        end
    end

    assign bus.pending_cnt = pending_cnt_q;

endmodule
